freq_gate_ctrl: RTL and testbench

Measurement sequencer for the frequency-meter datapath. It clears the two-digit BCD event counter, opens a gate window of exactly GATE_CYCLES reference clocks, and lets the counter settle after the gate closes. It then latches the BCD result and overflow status into stable display registers, and either repeats the cycle or returns to idle. It sits between the 50 MHz reference clock and the BCD counter, and owns the counter's clear and gate signals.

---
 rtl/freq_pkg.sv | 22 ++
 rtl/freq_gate_ctrl_if.sv | 41 ++++
 rtl/freq_sync2.sv | 25 ++
 rtl/freq_gate_ctrl.sv | 163 ++++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_pkg.sv
// Shared types and default timing for the frequency-meter gate sequencer.
package freq_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH, HOLD} state_t;

    typedef logic [3:0] bcd_t;

    localparam int GATE_CYCLES_DEF   = 50_000_000;
    localparam int CLR_CYCLES_DEF    = 4;
    localparam int SETTLE_CYCLES_DEF = 8;
    localparam int HOLD_CYCLES_DEF   = 25_000_000;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Host/counter-side signal bundle of freq_gate_ctrl.
// FREQ_RANGE_EN adds the range select input and the latched res_range output.
interface freq_gate_ctrl_if;
    import freq_pkg::*;

    logic start;
    logic cont;
    bcd_t cnt_high;
    bcd_t cnt_low;
    logic cnt_cn;
    logic cnt_clr;
    logic gate;
    bcd_t res_high;
    bcd_t res_low;
    logic overflow;
    logic busy;
    logic done;
`ifdef FREQ_RANGE_EN
    logic range;
    logic res_range;

    modport master (
        output start, cont, cnt_high, cnt_low, cnt_cn, range,
        input  cnt_clr, gate, res_high, res_low, overflow, busy, done, res_range
    );
    modport slave (
        input  start, cont, cnt_high, cnt_low, cnt_cn, range,
        output cnt_clr, gate, res_high, res_low, overflow, busy, done, res_range
    );
`else
    modport master (
        output start, cont, cnt_high, cnt_low, cnt_cn,
        input  cnt_clr, gate, res_high, res_low, overflow, busy, done
    );
    modport slave (
        input  start, cont, cnt_high, cnt_low, cnt_cn,
        output cnt_clr, gate, res_high, res_low, overflow, busy, done
    );
`endif

endinterface

// File: rtl/freq_sync2.sv
// Two-flop synchronizer for the counter carry, followed by a rising-edge detector.
module freq_sync2 (
    input  logic clk_50MHz,
    input  logic clr_n,
    input  logic async_in,
    output logic rise
);

    logic sync_p0, sync_p1, sync_p2;

    always_ff @(posedge clk_50MHz or negedge clr_n) begin
        if (!clr_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= async_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~sync_p2;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer: clear counter, open gate window, settle, latch BCD result.
// FREQ_RANGE_EN enables the x10 range select (gate of GATE_CYCLES/10).
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES   = GATE_CYCLES_DEF,
    parameter int CLR_CYCLES    = CLR_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF
) (
    input  logic             clk_50MHz,
    input  logic             clr_n,
    freq_gate_ctrl_if.slave  bus
);

    localparam int MAX_CYC = max4(GATE_CYCLES, CLR_CYCLES, SETTLE_CYCLES, HOLD_CYCLES);
    localparam int TW      = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] CLR_LOAD    = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LOAD   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);

    state_t          state;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   gate_load;
    logic            ovf_seen;
    logic            ovf_rise;
    logic            cnt_clr_q, gate_q, busy_q, done_q, overflow_q;
    bcd_t            res_high_q, res_low_q;

    freq_sync2 u_sync (
        .clk_50MHz (clk_50MHz),
        .clr_n     (clr_n),
        .async_in  (bus.cnt_cn),
        .rise      (ovf_rise)
    );

`ifdef FREQ_RANGE_EN
    localparam logic [TW-1:0] GATE_RNG_LOAD = TW'(GATE_CYCLES / 10 - 1);

    logic range_q, res_range_q, enter_clear;

    assign enter_clear = (state == IDLE && (bus.start || bus.cont)) ||
                         (state == HOLD && timer == '0 && bus.cont);

    // Range is frozen at CLEAR entry so a mid-measurement change cannot skew the gate
    always_ff @(posedge clk_50MHz or negedge clr_n) begin
        if (!clr_n) begin
            range_q     <= 1'b0;
            res_range_q <= 1'b0;
        end else begin
            if (enter_clear)
                range_q <= bus.range;
            if (state == SETTLE && timer == '0)
                res_range_q <= range_q;
        end
    end

    assign gate_load     = range_q ? GATE_RNG_LOAD : GATE_LOAD;
    assign bus.res_range = res_range_q;
`else
    assign gate_load = GATE_LOAD;
`endif

    always_ff @(posedge clk_50MHz or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            timer      <= '0;
            ovf_seen   <= 1'b0;
            cnt_clr_q  <= 1'b0;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            res_high_q <= '0;
            res_low_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (ovf_rise && (state == GATE || state == SETTLE))
                ovf_seen <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.start || bus.cont) begin
                        state     <= CLEAR;
                        timer     <= CLR_LOAD;
                        cnt_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                CLEAR: begin
                    ovf_seen <= 1'b0;
                    if (timer == '0) begin
                        state     <= GATE;
                        timer     <= gate_load;
                        cnt_clr_q <= 1'b0;
                        gate_q    <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                GATE: begin
                    if (timer == '0) begin
                        state  <= SETTLE;
                        timer  <= SETTLE_LOAD;
                        gate_q <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                SETTLE: begin
                    if (timer == '0) begin
                        state      <= LATCH;
                        res_high_q <= bus.cnt_high;
                        res_low_q  <= bus.cnt_low;
                        overflow_q <= ovf_seen;
                        done_q     <= 1'b1;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                LATCH: begin
                    if (bus.cont) begin
                        state <= HOLD;
                        timer <= HOLD_LOAD;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (timer == '0) begin
                        if (bus.cont) begin
                            state     <= CLEAR;
                            timer     <= CLR_LOAD;
                            cnt_clr_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt_clr_q <= 1'b0;
                    gate_q    <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnt_clr  = cnt_clr_q;
    assign bus.gate     = gate_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.res_high = res_high_q;
    assign bus.res_low  = res_low_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Randomized bench for freq_gate_ctrl against a timeline model of one measurement.
// Exercises the range feature when FREQ_RANGE_EN is defined.
module tb_freq_gate_ctrl;
    import freq_pkg::*;

    localparam int G = 20;
    localparam int C = 4;
    localparam int S = 8;
    localparam int H = 5;

    logic clk_50MHz = 1'b0;
    logic clr_n     = 1'b0;

    always #10 clk_50MHz = ~clk_50MHz;

    freq_gate_ctrl_if bus ();

    freq_gate_ctrl #(
        .GATE_CYCLES   (G),
        .CLR_CYCLES    (C),
        .SETTLE_CYCLES (S),
        .HOLD_CYCLES   (H)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .clr_n     (clr_n),
        .bus       (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Model: k is the edge before the one that samples start, so offsets d match
    // the timing table (clear 1..C, gate C+1..C+gate, done at C+gate+S+1).
    int cyc = 0, k = 0, gm = G, plan_off = 0, force_off = -1;
    bit act = 0, ovf_m = 0, ovf_out_m = 0, rr_m = 0, rng_m = 0, cn_prev = 0;
    bit [3:0] rh_m = 0, rl_m = 0;
    int obs_clr, obs_gate, obs_done, first_done, steps_since;

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int done_off();
        return C + gm + S + 1;
    endfunction

    task automatic begin_meas();
        rng_m = 1'b0;
`ifdef FREQ_RANGE_EN
        rng_m = bus.range;
`endif
        gm    = rng_m ? G / 10 : G;
        ovf_m = 1'b0;
        if (force_off >= 0)
            plan_off = force_off;
        else
            plan_off = ($urandom_range(1, 0) == 1) ? int'($urandom_range(C + 1 + gm, C + 2)) : 0;
    endtask

    task automatic model_reset();
        act = 0; ovf_m = 0; ovf_out_m = 0; rr_m = 0; rh_m = 0; rl_m = 0; cn_prev = 0;
    endtask

    task automatic model_edge();
        int d;
        cyc++;
        if (!act) begin
            if (bus.start || bus.cont) begin
                act = 1;
                k   = cyc - 1;
                begin_meas();
            end
        end else begin
            d = cyc - k;
            // a carry seen while the gate is open must show up as overflow
            if (bus.cnt_cn && !cn_prev && d >= C + 2 && d <= C + 1 + gm)
                ovf_m = 1;
            if (d == done_off()) begin
                rh_m = bus.cnt_high; rl_m = bus.cnt_low; ovf_out_m = ovf_m; rr_m = rng_m;
            end else if (d == done_off() + 1 && !bus.cont) begin
                act = 0;
            end else if (d == done_off() + 1 + H) begin
                if (bus.cont) begin
                    k = cyc - 1;
                    begin_meas();
                end else begin
                    act = 0;
                end
            end
        end
        cn_prev = bus.cnt_cn;
    endtask

    task automatic check_all();
        int d;
        d = cyc - k;
        chk("cnt_clr",  bus.cnt_clr,  int'(act && d >= 1 && d <= C));
        chk("gate",     bus.gate,     int'(act && d >= C + 1 && d <= C + gm));
        chk("busy",     bus.busy,     int'(act));
        chk("done",     bus.done,     int'(act && d == done_off()));
        chk("res_high", bus.res_high, int'(rh_m));
        chk("res_low",  bus.res_low,  int'(rl_m));
        chk("overflow", bus.overflow, int'(ovf_out_m));
        chk("clr_gate_excl", int'(bus.cnt_clr & bus.gate), 0);
`ifdef FREQ_RANGE_EN
        chk("res_range", bus.res_range, int'(rr_m));
`endif
    endtask

    task automatic step();
        int dn;
        @(posedge clk_50MHz);
        model_edge();
        #1;
        check_all();
        steps_since++;
        obs_clr  += int'(bus.cnt_clr);
        obs_gate += int'(bus.gate);
        if (bus.done) begin
            obs_done++;
            if (first_done < 0) first_done = steps_since;
        end
        bus.start = 1'b0;
        dn = cyc + 1 - k;
        if (act)
            bus.cnt_cn = (plan_off != 0 && dn == plan_off);
        else
            bus.cnt_cn = ($urandom_range(23, 0) == 0);
    endtask

    task automatic begin_obs();
        obs_clr = 0; obs_gate = 0; obs_done = 0; first_done = -1; steps_since = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int last_done;
        int g;

        bus.start = 0; bus.cont = 0; bus.cnt_high = 0; bus.cnt_low = 0; bus.cnt_cn = 0;
`ifdef FREQ_RANGE_EN
        bus.range = 0;
`endif
        repeat (2) @(posedge clk_50MHz);
        #1;
        model_reset();
        check_all();
        #4 clr_n = 1'b1;

        // single shot
        bus.cnt_high = 4'd3; bus.cnt_low = 4'd7; force_off = 0;
        begin_obs();
        bus.start = 1'b1;
        run(45);
        chk("ss_clr_len",  obs_clr, C);
        chk("ss_gate_len", obs_gate, G);
        chk("ss_done_lat", first_done, C + G + S + 1);
        chk("ss_res",      {bus.res_high, bus.res_low}, 8'h37);
        chk("ss_ovf",      bus.overflow, 0);
        chk("ss_idle",     bus.busy, 0);

        // carry in the last gate cycle, then a clean run
        force_off = C + 1 + G;
        bus.start = 1'b1;
        run(40);
        chk("ovf_last_gate", bus.overflow, 1);
        force_off = 0;
        bus.start = 1'b1;
        run(40);
        chk("ovf_cleared", bus.overflow, 0);

        // start during the gate must be ignored
        begin_obs();
        bus.start = 1'b1;
        run(12);
        bus.start = 1'b1;
        run(40);
        chk("ign_done_cnt", obs_done, 1);
        chk("ign_done_lat", first_done, C + G + S + 1);

        // asynchronous reset in the middle of the gate
        bus.start = 1'b1;
        run(15);
        bus.cnt_cn = 1'b0;
        #4 clr_n = 1'b0;
        #2;
        model_reset();
        check_all();
        #3 clr_n = 1'b1;
        begin_obs();
        bus.start = 1'b1;
        run(40);
        chk("rst_done_lat", first_done, C + G + S + 1);
        chk("rst_gate_len", obs_gate, G);

        // continuous mode, then drop cont inside a gate
        force_off = -1;
        bus.cont  = 1'b1;
        last_done = -1;
        for (int i = 0; i < 120; i++) begin
            step();
            if (bus.done) begin
                if (last_done >= 0) chk("cont_period", cyc - last_done, C + G + S + 1 + H);
                last_done = cyc;
            end
        end
        g = 0;
        while (g < 60 && !(act && (cyc - k) >= C + 5 && (cyc - k) <= C + G - 2)) begin
            step();
            g++;
        end
        chk("cont_reach_gate", int'(g < 60), 1);
        bus.cont = 1'b0;
        begin_obs();
        run(60);
        chk("cont_tail_done", obs_done, 1);
        chk("cont_tail_idle", bus.busy, 0);

`ifdef FREQ_RANGE_EN
        bus.range = 1'b1;
        begin_obs();
        bus.start = 1'b1;
        run(25);
        chk("rng_gate_len",  obs_gate, G / 10);
        chk("rng_res_range", bus.res_range, 1);
        bus.range = 1'b0;
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11, 0) == 0) bus.start = 1'b1;
            if ($urandom_range(63, 0) == 0) bus.cont = ~bus.cont;
            if ($urandom_range(3, 0) == 0) begin
                bus.cnt_high = 4'($urandom_range(9, 0));
                bus.cnt_low  = 4'($urandom_range(9, 0));
            end
`ifdef FREQ_RANGE_EN
            if ($urandom_range(7, 0) == 0) bus.range = ~bus.range;
`endif
            step();
        end
        bus.cont = 1'b0;
        run(60);
        chk("final_idle", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
